conv_loop_ctrl: RTL and testbench

Loop sequencer for the first convolution layer engine. It is enabled by the layer-level controller's L1 enable and reports completion on its L1 done input. While enabled, it walks output channel, output row, output column and kernel window. Each cycle it issues one feature-map/weight read address pair, aligns the MAC control strobes to the one-cycle memory latency, and writes each finished accumulator to output feature-map memory.

---
 rtl/conv_loop_ctrl.sv | 92 +++++++++
 tb/tb_conv_loop_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: convolution loop sequencer issuing ifm/weight reads, MAC strobes and ofm writes
module conv_loop_ctrl #(
  parameter int IN_W   = 32,
  parameter int K      = 5,
  parameter int OUT_CH = 6,
  parameter int IFM_AW = 10,
  parameter int W_AW   = 8,
  parameter int OFM_AW = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              done,
  output logic              rd_en,
  output logic [IFM_AW-1:0] ifm_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic              mac_valid,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              ofm_we,
  output logic [OFM_AW-1:0] ofm_addr,
  output logic [2:0]        oc_idx
);
  localparam int OUT_W = IN_W - K + 1;
  localparam int KW = K > 1 ? $clog2(K) : 1;
  localparam int OW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  localparam int CW = OUT_CH > 1 ? $clog2(OUT_CH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [CW-1:0] oc_q, oc_d;
  logic [OFM_AW-1:0] pix_q, pix_d;
  logic [2:0] oc_s_q;
  logic kx_end, ky_end, ox_end, oy_end, oc_end, tap_end, last_tap, abort;
  always_comb begin
    kx_end   = kx_q == KW'(K - 1);
    ky_end   = ky_q == KW'(K - 1);
    ox_end   = ox_q == OW'(OUT_W - 1);
    oy_end   = oy_q == OW'(OUT_W - 1);
    oc_end   = oc_q == CW'(OUT_CH - 1);
    tap_end  = kx_end && ky_end;
    last_tap = tap_end && ox_end && oy_end && oc_end;
    abort    = !en && state_q != IDLE;
    rd_en    = state_q == RUN;
    done     = state_q == DONE;
    state_d  = (state_q == IDLE && en) ? RUN :
               (state_q == RUN && last_tap) ? DRAIN :
               (state_q == DRAIN && ofm_we) ? DONE : state_q;
    kx_d = rd_en ? (kx_end ? '0 : kx_q + KW'(1)) : kx_q;
    ky_d = (rd_en && kx_end) ? (ky_end ? '0 : ky_q + KW'(1)) : ky_q;
    ox_d = (rd_en && tap_end) ? (ox_end ? '0 : ox_q + OW'(1)) : ox_q;
    oy_d = (rd_en && tap_end && ox_end) ? (oy_end ? '0 : oy_q + OW'(1)) : oy_q;
    oc_d = (rd_en && tap_end && ox_end && oy_end) ? (oc_end ? '0 : oc_q + CW'(1)) : oc_q;
    ifm_addr = IFM_AW'((32'(oy_q) + 32'(ky_q)) * IN_W + 32'(ox_q) + 32'(kx_q));
    w_addr   = W_AW'(32'(oc_q) * K * K + 32'(ky_q) * K + 32'(kx_q));
    pix_d    = OFM_AW'(32'(oc_q) * OUT_W * OUT_W + 32'(oy_q) * OUT_W + 32'(ox_q));
  end
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q   <= IDLE;
      kx_q      <= '0;
      ky_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      oc_q      <= '0;
      mac_valid <= 1'b0;
      acc_clr   <= 1'b0;
      acc_last  <= 1'b0;
      pix_q     <= '0;
      oc_s_q    <= '0;
      ofm_we    <= 1'b0;
      ofm_addr  <= '0;
      oc_idx    <= '0;
    end else begin
      state_q   <= state_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      oc_q      <= oc_d;
      mac_valid <= rd_en;
      acc_clr   <= rd_en && kx_q == '0 && ky_q == '0;
      acc_last  <= rd_en && tap_end;
      pix_q     <= pix_d;
      oc_s_q    <= 3'(oc_q);
      ofm_we    <= acc_last;
      ofm_addr  <= pix_q;
      oc_idx    <= oc_s_q;
    end
  end
endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: randomized self-checking bench for conv_loop_ctrl on a 4x4 input, 3x3 kernel, 2 channels
module tb_conv_loop_ctrl;
  localparam int IN_W = 4;
  localparam int K = 3;
  localparam int OUT_CH = 2;
  localparam int IFM_AW = 4;
  localparam int W_AW = 5;
  localparam int OFM_AW = 3;
  localparam int OUT_W = IN_W - K + 1;
  localparam int NPIX = OUT_CH * OUT_W * OUT_W;
  localparam int N = NPIX * K * K;
  localparam int NC = N + 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic done, rd_en, mac_valid, acc_clr, acc_last, ofm_we;
  logic [IFM_AW-1:0] ifm_addr;
  logic [W_AW-1:0] w_addr;
  logic [OFM_AW-1:0] ofm_addr;
  logic [2:0] oc_idx;
  int tests = 0;
  int fails = 0;
  bit exp_rd[NC], exp_mv[NC], exp_clr[NC], exp_last[NC], exp_we[NC];
  int exp_ifm[NC], exp_w[NC], exp_oa[NC], exp_oc[NC];
  int ifm_mem[IN_W*IN_W];
  int w_mem[OUT_CH*K*K];
  int res[NPIX];
  conv_loop_ctrl #(.IN_W(IN_W), .K(K), .OUT_CH(OUT_CH), .IFM_AW(IFM_AW), .W_AW(W_AW), .OFM_AW(OFM_AW)) dut (
    .clk(clk), .rst(rst), .en(en), .done(done), .rd_en(rd_en), .ifm_addr(ifm_addr), .w_addr(w_addr),
    .mac_valid(mac_valid), .acc_clr(acc_clr), .acc_last(acc_last), .ofm_we(ofm_we), .ofm_addr(ofm_addr),
    .oc_idx(oc_idx)
  );
  always #5 clk = ~clk;
  task automatic build_model();
    int t = 0;
    for (int c = 0; c < NC; c++) begin
      exp_rd[c] = 0; exp_mv[c] = 0; exp_clr[c] = 0; exp_last[c] = 0; exp_we[c] = 0;
      exp_ifm[c] = 0; exp_w[c] = 0; exp_oa[c] = 0; exp_oc[c] = 0;
    end
    for (int oc = 0; oc < OUT_CH; oc++)
      for (int oy = 0; oy < OUT_W; oy++)
        for (int ox = 0; ox < OUT_W; ox++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              int c = t + 1;
              exp_rd[c] = 1;
              exp_ifm[c] = (oy + ky) * IN_W + ox + kx;
              exp_w[c] = oc * K * K + ky * K + kx;
              exp_mv[c+1] = 1;
              exp_clr[c+1] = (ky == 0 && kx == 0);
              exp_last[c+1] = (ky == K-1 && kx == K-1);
              if (ky == K-1 && kx == K-1) begin
                exp_we[c+2] = 1;
                exp_oa[c+2] = oc * OUT_W * OUT_W + oy * OUT_W + ox;
                exp_oc[c+2] = oc;
              end
              t++;
            end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({done, rd_en, mac_valid, acc_clr, acc_last, ofm_we, ifm_addr, w_addr, ofm_addr, oc_idx} !== '0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got rd_en=%b done=%b ofm_we=%b ifm=%0d w=%0d, want all 0", i, rd_en, done, ofm_we, ifm_addr, w_addr);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (rd_en !== 1'b1 || ifm_addr !== '0 || w_addr !== '0) begin
      fails++;
      $display("FAIL reset_first_rd: got rd_en=%b ifm=%0d w=%0d, want 1 0 0", rd_en, ifm_addr, w_addr);
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic test_full_run(input string tag);
    int acc = 0;
    int pa_i = 0;
    int pa_w = 0;
    int nwe = 0;
    bit pa_v = 0;
    for (int i = 0; i < IN_W*IN_W; i++) ifm_mem[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < OUT_CH*K*K; i++) w_mem[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < NPIX; i++) res[i] = 32'h7fff_ffff;
    en = 1'b1;
    for (int c = 1; c <= N + 5; c++) begin
      @(negedge clk);
      tests++;
      if (rd_en !== exp_rd[c] || done !== (c >= N + 3) || mac_valid !== exp_mv[c] || acc_clr !== exp_clr[c]
          || acc_last !== exp_last[c] || ofm_we !== exp_we[c]) begin
        fails++;
        $display("FAIL %s_strobes cycle %0d: got rd=%b mv=%b clr=%b last=%b we=%b done=%b, want %b %b %b %b %b %b",
                 tag, c, rd_en, mac_valid, acc_clr, acc_last, ofm_we, done,
                 exp_rd[c], exp_mv[c], exp_clr[c], exp_last[c], exp_we[c], c >= N + 3);
      end
      if (exp_rd[c]) begin
        tests++;
        if (ifm_addr !== IFM_AW'(exp_ifm[c]) || w_addr !== W_AW'(exp_w[c])) begin
          fails++;
          $display("FAIL %s_rd_addr cycle %0d: got ifm=%0d w=%0d, want %0d %0d", tag, c, ifm_addr, w_addr, exp_ifm[c], exp_w[c]);
        end
      end
      if (exp_we[c]) begin
        tests++;
        if (ofm_addr !== OFM_AW'(exp_oa[c]) || oc_idx !== 3'(exp_oc[c])) begin
          fails++;
          $display("FAIL %s_ofm_addr cycle %0d: got addr=%0d oc=%0d, want %0d %0d", tag, c, ofm_addr, oc_idx, exp_oa[c], exp_oc[c]);
        end
      end
      if (ofm_we === 1'b1) begin
        nwe++;
        if (int'(ofm_addr) < NPIX) res[ofm_addr] = acc;
      end
      if (mac_valid === 1'b1 && pa_v) begin
        int prod = ifm_mem[pa_i] * w_mem[pa_w];
        acc = (acc_clr === 1'b1) ? prod : acc + prod;
      end
      pa_v = (rd_en === 1'b1);
      pa_i = int'(ifm_addr) % (IN_W*IN_W);
      pa_w = int'(w_addr) % (OUT_CH*K*K);
    end
    tests++;
    if (nwe != NPIX) begin
      fails++;
      $display("FAIL %s_we_count: got %0d, want %0d", tag, nwe, NPIX);
    end
    for (int oc = 0; oc < OUT_CH; oc++)
      for (int oy = 0; oy < OUT_W; oy++)
        for (int ox = 0; ox < OUT_W; ox++) begin
          int sum = 0;
          int p = oc * OUT_W * OUT_W + oy * OUT_W + ox;
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              sum += ifm_mem[(oy + ky) * IN_W + ox + kx] * w_mem[oc * K * K + ky * K + kx];
          tests++;
          if (res[p] != sum) begin
            fails++;
            $display("FAIL %s_conv pixel %0d: got %0d, want %0d", tag, p, res[p], sum);
          end
        end
  endtask
  task automatic test_rerun();
    en = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("FAIL rerun_idle: got done=%b rd_en=%b, want 0 0", done, rd_en);
    end
    test_full_run("rerun");
  endtask
  task automatic test_abort(input int ac);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    for (int c = 1; c <= ac; c++) @(negedge clk);
    en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if ({done, rd_en, mac_valid, acc_clr, acc_last, ofm_we, ifm_addr, w_addr, ofm_addr, oc_idx} !== '0) begin
        fails++;
        $display("FAIL abort_%0d_quiet +%0d: got rd=%b mv=%b we=%b done=%b ifm=%0d, want all 0", ac, k, rd_en, mac_valid, ofm_we, done, ifm_addr);
      end
    end
    en = 1'b1;
    @(negedge clk);
    tests++;
    if (rd_en !== 1'b1 || ifm_addr !== '0 || w_addr !== '0) begin
      fails++;
      $display("FAIL abort_%0d_restart: got rd=%b ifm=%0d w=%0d, want 1 0 0", ac, rd_en, ifm_addr, w_addr);
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  initial begin
    build_model();
    test_reset();
    test_full_run("run");
    test_rerun();
    test_abort(20);
    test_abort(10);
    test_abort(int'($urandom_range(2, N)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
